// File: rtl/dense_vector_serializer_if.sv
// Handshake bundle around the serializer: parallel vector in, chunked stream out.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface dense_vector_serializer_if #(
    parameter int IN_SIZE  = 128,
    parameter int OUT_SIZE = 4,
    parameter int BW       = 16
);
    logic                             vld_in;
    logic                             rdy_in;
    logic [IN_SIZE-1:0][BW-1:0]       data_in;
    logic                             rdy_out;
    logic                             vld_out;
    logic [OUT_SIZE-1:0][BW-1:0]      data_out;
    logic                             first_out;
    logic                             last_out;

    modport master (
        output vld_in, data_in, rdy_out,
        input  rdy_in, vld_out, data_out, first_out, last_out
    );

    modport slave (
        input  vld_in, data_in, rdy_out,
        output rdy_in, vld_out, data_out, first_out, last_out
    );
endinterface

// File: rtl/dense_vector_serializer.sv
// Ping-pong buffered parallel-to-chunk serializer between two dense layers.
// Two full vectors can be held; one drains OUT_SIZE words per transfer while the other fills.
module dense_vector_serializer #(
    parameter int IN_SIZE  = 128,
    parameter int OUT_SIZE = 4,
    parameter int BW       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dense_vector_serializer_if.slave  bus
);

    localparam int NUM_CYC = IN_SIZE / OUT_SIZE;
    localparam int CW      = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CYC - 1);

    if (IN_SIZE % OUT_SIZE != 0) begin : g_bad_size
        $error("dense_vector_serializer: IN_SIZE must be a multiple of OUT_SIZE");
    end

    typedef logic [IN_SIZE-1:0][BW-1:0]                vec_t;
    typedef logic [NUM_CYC-1:0][OUT_SIZE-1:0][BW-1:0]  chunked_t;

    logic [1:0]    full_q,   full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] idx_q,    idx_d;
    vec_t          buf_q [2];
    vec_t          buf_d [2];

    logic     rdy;
    logic     vld;
    logic     accept;
    logic     xfer;
    logic     at_last;
    chunked_t rd_vec;

    // The write target must be empty and the read target full, so an accept and
    // a final-chunk drain in the same cycle always touch different buffers.
    always_comb begin
        rdy      = !full_q[wr_sel_q];
        vld      = full_q[rd_sel_q];
        accept   = bus.vld_in && rdy;
        xfer     = vld && bus.rdy_out;
        at_last  = (idx_q == LAST_IDX);

        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        idx_d    = idx_q;

        if (accept) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end

        if (xfer) begin
            if (at_last) begin
                idx_d            = '0;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (accept) begin
            buf_d[wr_sel_q] = bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            idx_q    <= idx_d;
        end
    end

    // Vector storage carries no reset; the full flags alone decide what is visible.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign rd_vec = buf_q[rd_sel_q];

    assign bus.rdy_in    = rdy;
    assign bus.vld_out   = vld;
    assign bus.data_out  = vld ? rd_vec[idx_q] : '0;
    assign bus.first_out = vld && (idx_q == '0);
    assign bus.last_out  = vld && at_last;

endmodule

// File: tb/tb_dense_vector_serializer.sv
// Randomized and directed bench for dense_vector_serializer against a queue-based vector model.
// A second instance exercises the single-chunk corner (IN_SIZE == OUT_SIZE).
module tb_dense_vector_serializer;

    localparam int IN  = 128;
    localparam int OUT = 4;
    localparam int BW  = 16;
    localparam int NC  = IN / OUT;

    typedef logic [IN-1:0][BW-1:0]  vec_t;
    typedef logic [OUT-1:0][BW-1:0] chunk_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dense_vector_serializer_if #(.IN_SIZE(IN), .OUT_SIZE(OUT), .BW(BW)) bus ();
    dense_vector_serializer_if #(.IN_SIZE(4),  .OUT_SIZE(4),   .BW(BW)) bus2 ();

    dense_vector_serializer #(.IN_SIZE(IN), .OUT_SIZE(OUT), .BW(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dense_vector_serializer #(.IN_SIZE(4), .OUT_SIZE(4), .BW(BW)) dut_corner (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_hs  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t ramp(input int base);
        vec_t v;
        for (int k = 0; k < IN; k++) v[k] = BW'(base + k);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < IN; k++) v[k] = BW'($urandom);
        return v;
    endfunction

    function automatic chunk_t lit_chunk(input int base);
        chunk_t r;
        for (int j = 0; j < OUT; j++) r[j] = BW'(base + j);
        return r;
    endfunction

    function automatic chunk_t slice(input vec_t v, input int c);
        chunk_t r;
        for (int j = 0; j < OUT; j++) r[j] = v[c*OUT + j];
        return r;
    endfunction

    // Reference: a FIFO of at most two accepted vectors and the chunk position in the head.
    vec_t vq[$];
    int   pos = 0;

    always @(negedge rst_n) begin
        vq.delete();
        pos = 0;
    end

    always @(posedge clk) begin : model_step
        bit   do_xfer;
        bit   do_acc;
        vec_t din;
        if (rst_n) begin
            do_xfer = (vq.size() > 0) && bus.rdy_out;
            do_acc  = bus.vld_in && (vq.size() < 2);
            din     = bus.data_in;
            if (do_xfer) begin
                if (pos == NC - 1) begin
                    void'(vq.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            if (do_acc) vq.push_back(din);
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.vld_out && bus.rdy_out) n_hs++;
    end

    always @(negedge clk) begin : compare
        chunk_t ec;
        bit     ev;
        ev = (vq.size() > 0);
        ec = '0;
        if (ev) ec = slice(vq[0], pos);
        chk("rdy_in",    64'(bus.rdy_in),    64'(vq.size() < 2));
        chk("vld_out",   64'(bus.vld_out),   64'(ev));
        chk("data_out",  bus.data_out,       ec);
        chk("first_out", 64'(bus.first_out), 64'(ev && pos == 0));
        chk("last_out",  64'(bus.last_out),  64'(ev && pos == NC - 1));
    end

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (bus.vld_out && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 64'(bus.vld_out), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        va, vb, vc;
        int          cnt0, acc_i, x0;
        logic [63:0] d2 [8];

        bus.vld_in   = 1'b0;
        bus.data_in  = '0;
        bus.rdy_out  = 1'b1;
        bus2.vld_in  = 1'b0;
        bus2.data_in = '0;
        bus2.rdy_out = 1'b1;

        #1 rst_n = 1'b0;
        #2;
        chk("reset_vld",   64'(bus.vld_out),   64'(0));
        chk("reset_rdy",   64'(bus.rdy_in),    64'(1));
        chk("reset_first", 64'(bus.first_out), 64'(0));
        chk("reset_last",  64'(bus.last_out),  64'(0));
        chk("reset_data",  bus.data_out,       64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single vector, word k = k.
        va = ramp(0);
        x0 = n_hs;
        @(posedge clk); #1 bus.vld_in = 1'b1; bus.data_in = va;
        @(posedge clk); #1 bus.vld_in = 1'b0;
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            chk("single_vld",   64'(bus.vld_out),   64'(1));
            chk("single_data",  bus.data_out,       lit_chunk(4*c));
            chk("single_first", 64'(bus.first_out), 64'(c == 0));
            chk("single_last",  64'(bus.last_out),  64'(c == NC - 1));
        end
        @(negedge clk);
        chk("single_idle",  64'(bus.vld_out), 64'(0));
        chk("single_xfers", 64'(n_hs - x0),   64'(NC));

        // Downstream stall at chunk 7.
        x0 = n_hs;
        @(posedge clk); #1 bus.vld_in = 1'b1; bus.data_in = va;
        @(posedge clk); #1 bus.vld_in = 1'b0;
        for (int c = 0; c < 8; c++) @(negedge clk);
        chk("stall_chunk7", bus.data_out, lit_chunk(28));
        bus.rdy_out = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_hold_data", bus.data_out,       lit_chunk(28));
            chk("stall_hold_vld",  64'(bus.vld_out),   64'(1));
        end
        bus.rdy_out = 1'b1;
        @(negedge clk);
        chk("stall_resume", bus.data_out, lit_chunk(32));
        wait_idle(NC + 5);
        chk("stall_xfers", 64'(n_hs - x0), 64'(NC));

        // Back-to-back A, B with C held on vld_in until it is taken.
        va = ramp(0);
        vb = ramp(1000);
        vc = ramp(2000);
        @(posedge clk); #1 bus.vld_in = 1'b1; bus.data_in = va;
        @(posedge clk); #1 bus.data_in = vb;
        @(negedge clk);
        chk("b2b_a0",     bus.data_out,     lit_chunk(0));
        chk("b2b_rdy_hi", 64'(bus.rdy_in),  64'(1));
        @(posedge clk); #1 bus.data_in = vc;
        cnt0  = 0;
        acc_i = -1;
        for (int i = 1; i < 3*NC; i++) begin
            @(negedge clk);
            chk("b2b_vld", 64'(bus.vld_out), 64'(1));
            if (i == 1) chk("b2b_rdy_low", 64'(bus.rdy_in), 64'(0));
            if (i <= NC && !bus.rdy_in) cnt0++;
            if (i == NC) begin
                chk("b2b_rdy_back", 64'(bus.rdy_in),    64'(1));
                chk("b2b_b0",       bus.data_out,       lit_chunk(1000));
                chk("b2b_b0_first", 64'(bus.first_out), 64'(1));
            end
            if (i == 2*NC) begin
                chk("b2b_c0",       bus.data_out,       lit_chunk(2000));
                chk("b2b_c0_first", 64'(bus.first_out), 64'(1));
            end
            if (bus.vld_in && bus.rdy_in) begin
                acc_i = i;
                @(posedge clk); #1 bus.vld_in = 1'b0;
            end
        end
        chk("b2b_rdy_low_cycles", 64'(cnt0),  64'(NC - 1));
        chk("c_accept_cycle",     64'(acc_i), 64'(NC));
        @(negedge clk);
        wait_idle(5);

        // Asynchronous reset at chunk 10 of A while B is buffered.
        va = rand_vec();
        vb = rand_vec();
        @(posedge clk); #1 bus.vld_in = 1'b1; bus.data_in = va;
        @(posedge clk); #1 bus.data_in = vb;
        @(posedge clk); #1 bus.vld_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_pre_chunk10", bus.data_out, slice(va, 10));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_vld",   64'(bus.vld_out),   64'(0));
        chk("rst_async_rdy",   64'(bus.rdy_in),    64'(1));
        chk("rst_async_data",  bus.data_out,       64'(0));
        chk("rst_async_first", 64'(bus.first_out), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        x0 = n_hs;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(bus.vld_out), 64'(0));
            chk("post_rst_rdy",  64'(bus.rdy_in),  64'(1));
        end
        chk("post_rst_no_xfer", 64'(n_hs - x0), 64'(0));
        vc = rand_vec();
        @(posedge clk); #1 bus.vld_in = 1'b1; bus.data_in = vc;
        @(posedge clk); #1 bus.vld_in = 1'b0;
        @(negedge clk);
        chk("post_rst_first", 64'(bus.first_out), 64'(1));
        chk("post_rst_data",  bus.data_out,       slice(vc, 0));
        wait_idle(NC + 5);

        // Random traffic with a mid-stream asynchronous reset.
        for (int t = 0; t < 600; t++) begin
            @(posedge clk); #1;
            bus.vld_in  = ($urandom_range(0, 2) != 0);
            bus.data_in = rand_vec();
            bus.rdy_out = ($urandom_range(0, 3) != 0);
            if (t == 300) begin
                #3 rst_n = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
            end
        end
        @(posedge clk); #1 bus.vld_in = 1'b0; bus.rdy_out = 1'b1;
        @(negedge clk);
        wait_idle(3*NC);

        // Single-chunk corner: one vector per cycle, one chunk each.
        for (int i = 0; i < 8; i++) d2[i] = {$urandom, $urandom};
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i < 8) begin
                bus2.vld_in  = 1'b1;
                bus2.data_in = d2[i];
            end else begin
                bus2.vld_in = 1'b0;
            end
            @(negedge clk);
            if (i >= 1) begin
                chk("corner_vld",   64'(bus2.vld_out),   64'(1));
                chk("corner_data",  bus2.data_out,       d2[i-1]);
                chk("corner_first", 64'(bus2.first_out), 64'(1));
                chk("corner_last",  64'(bus2.last_out),  64'(1));
                chk("corner_rdy",   64'(bus2.rdy_in),    64'(1));
            end
        end
        @(negedge clk);
        chk("corner_idle", 64'(bus2.vld_out), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
